// File: rtl/div_if.sv
// Divide request/response bundle between EX decode and the divide controller.
// The master drives the request side; the slave returns stall, ready and result.
interface div_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic                   signed_div;
    logic [WIDTH-1:0]       opdata1;
    logic [WIDTH-1:0]       opdata2;
    logic                   annul;
    logic                   stall_req;
    logic                   ready;
    logic [2*WIDTH-1:0]     result;

    modport master (
        output start, signed_div, opdata1, opdata2, annul,
        input  stall_req, ready, result
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2, annul,
        output stall_req, ready, result
    );
endinterface

// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divide controller for DIV/DIVU.
// Returns {remainder, quotient} in HI/LO packing and stalls the pipeline while busy.
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic   clk,
    input  logic   resetn,
    div_if.slave   dbus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [2*WIDTH:0]       div_r;
    logic [WIDTH-1:0]       divisor_r;
    logic                   neg_q_r;
    logic                   neg_r_r;
    logic [2*WIDTH-1:0]     result_r;

    logic [2*WIDTH:0]       shifted_s;
    logic [WIDTH:0]         diff_s;
    logic [2*WIDTH:0]       iter_s;
    logic [WIDTH-1:0]       quo_s;
    logic [WIDTH-1:0]       rem_s;
    logic                   op2_zero_s;

    // Two's complement negate when enabled; wraps for the most negative value.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + WIDTH'(1)) : v;
    endfunction

    // Unsigned magnitude of an operand; only signed operands with MSB set are negated.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return cond_neg(v, sgn & v[WIDTH-1]);
    endfunction

    assign op2_zero_s = (dbus.opdata2 == {WIDTH{1'b0}});

    // One restoring iteration: shift, trial-subtract, keep difference if non-negative.
    always_comb begin
        shifted_s = {div_r[2*WIDTH-1:0], 1'b0};
        diff_s    = shifted_s[2*WIDTH:WIDTH] - {1'b0, divisor_r};
        if (!diff_s[WIDTH]) begin
            iter_s = {diff_s, shifted_s[WIDTH-1:1], 1'b1};
        end else begin
            iter_s = shifted_s;
        end
        quo_s = cond_neg(iter_s[WIDTH-1:0], neg_q_r);
        rem_s = cond_neg(iter_s[2*WIDTH-1:WIDTH], neg_r_r);
    end

    // Next-state logic; annul overrides every state.
    always_comb begin
        state_s = state_r;
        if (dbus.annul) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (dbus.start) begin
                        state_s = op2_zero_s ? BYZERO : ON;
                    end else begin
                        state_s = IDLE;
                    end
                end
                BYZERO: state_s = END;
                ON: begin
                    if (cnt_r == CNT_LAST) begin
                        state_s = END;
                    end else begin
                        state_s = ON;
                    end
                end
                END: begin
                    if (dbus.start) begin
                        state_s = END;
                    end else begin
                        state_s = IDLE;
                    end
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture and iteration datapath; operands are sampled only on leaving IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r     <= {CNT_W{1'b0}};
            div_r     <= {(2*WIDTH+1){1'b0}};
            divisor_r <= {WIDTH{1'b0}};
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
        end else if (state_r == IDLE && state_s == ON) begin
            cnt_r     <= {CNT_W{1'b0}};
            div_r     <= {{(WIDTH+1){1'b0}}, mag(dbus.opdata1, dbus.signed_div)};
            divisor_r <= mag(dbus.opdata2, dbus.signed_div);
            neg_q_r   <= dbus.signed_div & (dbus.opdata1[WIDTH-1] ^ dbus.opdata2[WIDTH-1]);
            neg_r_r   <= dbus.signed_div & dbus.opdata1[WIDTH-1];
        end else if (state_r == ON) begin
            cnt_r     <= cnt_r + CNT_W'(1);
            div_r     <= iter_s;
        end else begin
            cnt_r     <= cnt_r;
            div_r     <= div_r;
        end
    end

    // Result register: updated only when entering END, so cancelled ops leave it intact.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result_r <= {(2*WIDTH){1'b0}};
        end else if (state_r == BYZERO && state_s == END) begin
            result_r <= {(2*WIDTH){1'b0}};
        end else if (state_r == ON && state_s == END) begin
            result_r <= {rem_s, quo_s};
        end else begin
            result_r <= result_r;
        end
    end

    assign dbus.stall_req = dbus.start & ~dbus.annul & (state_r != END) & resetn;
    assign dbus.ready     = (state_r == END) & ~dbus.annul;
    assign dbus.result    = result_r;
endmodule
